// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block.
//   state_e        : measurement state machine encoding
//   CNT_WIDTH_DEF  : default width of the period/high counters
//   CNT_SAT_DEF    : saturated (all-ones) count at the default width
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int CNT_WIDTH_DEF = 17;

  localparam logic [CNT_WIDTH_DEF-1:0] CNT_SAT_DEF = '1;

endpackage

// File: rtl/pwm_edge_sync.sv
// Input synchronizer and edge detector for an asynchronous PWM line.
// Ports:
//   clk      : system clock
//   syn_rst  : synchronous reset, active-high
//   pwm_in   : asynchronous PWM waveform
//   s        : pwm_in after SYNC_STAGES flops
//   rise     : s went 0 -> 1 this cycle
//   fall     : s went 1 -> 0 this cycle
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic syn_rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  // Synchronizer chain, then one extra flop to compare against for edges
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time (in clk cycles) of an
// asynchronous PWM input and flags a line that stops toggling.
// Ports:
//   clk         : system clock
//   syn_rst     : synchronous reset, active-high
//   pwm_in      : asynchronous PWM waveform
//   meas_period : cycles between the last two rising edges
//   meas_high   : cycles high within that period
//   meas_valid  : one-cycle strobe when meas_period/meas_high update
//   stuck_high  : no edge for 2^CNT_WIDTH-1 cycles with the line high
//   stuck_low   : no edge for 2^CNT_WIDTH-1 cycles with the line low
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 syn_rst,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] meas_period,
  output logic [CNT_WIDTH-1:0] meas_high,
  output logic                 meas_valid,
  output logic                 stuck_high,
  output logic                 stuck_low
);

  localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 s;
  logic                 rise;
  logic                 fall;
  state_e               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] hi_len;

  // True on the cycle whose increment would land on all-ones. The >= also
  // catches a count already parked at all-ones (fall taken on the limit
  // cycle), so the counter can never wrap.
  function automatic logic at_limit(input logic [CNT_WIDTH-1:0] c);
    return c >= (CNT_SAT - CNT_ONE);
  endfunction

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .syn_rst(syn_rst),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  // Measurement state machine; cnt counts the rise cycle as cycle 1
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_len      <= '0;
      meas_period <= '0;
      meas_high   <= '0;
      meas_valid  <= 1'b0;
      stuck_high  <= 1'b0;
      stuck_low   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      // Any edge proves the line is alive again
      if (rise || fall) begin
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end

      case (state)
        IDLE: begin
          // First rise only arms; there is no previous rise to measure from
          if (rise) begin
            state <= HIGH;
            cnt   <= CNT_ONE;
          end
        end

        HIGH: begin
          if (fall) begin
            state  <= LOW;
            hi_len <= cnt;
            cnt    <= cnt + CNT_ONE;
          end else if (at_limit(cnt)) begin
            state      <= IDLE;
            cnt        <= CNT_SAT;
            stuck_high <= s;
            stuck_low  <= ~s;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        LOW: begin
          if (rise) begin
            state       <= HIGH;
            meas_period <= cnt;
            meas_high   <= hi_len;
            meas_valid  <= 1'b1;
            cnt         <= CNT_ONE;
          end else if (at_limit(cnt)) begin
            state      <= IDLE;
            cnt        <= CNT_SAT;
            stuck_high <= s;
            stuck_low  <= ~s;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator.
- Samples an asynchronous PWM waveform and measures its period and high time in clk cycles.
- Publishes each completed measurement with a one-cycle valid strobe.
- Flags a line stuck high or stuck low (0 % / 100 % duty, or no source). Sits at a board input pin, feeding control/monitor logic.

Parameters:
- CNT_WIDTH, 17, width of the period/high counters. Must hold the longest expected period; a 2^16-cycle period needs 17 bits.
- SYNC_STAGES, 2, number of input synchronizer flops (minimum 2).

Ports:
- clk  input  1  system clock
- syn_rst  input  1  synchronous reset, active-high
- pwm_in  input  1  asynchronous PWM waveform
- meas_period  output  CNT_WIDTH  cycles between the last two rising edges
- meas_high  output  CNT_WIDTH  cycles high within that period
- meas_valid  output  1  one-cycle strobe when meas_period/meas_high update
- stuck_high  output  1  no edge for 2^CNT_WIDTH-1 cycles, line high
- stuck_low  output  1  no edge for 2^CNT_WIDTH-1 cycles, line low

Behaviour:
- Reset (syn_rst=1 at a clk edge):
  - synchronizer flops, s_d, cnt, hi_len = 0.
  - meas_period = 0, meas_high = 0, meas_valid = 0, stuck_high = 0, stuck_low = 0.
  - state = IDLE.
  - Reset mid-measurement discards the partial period.
- Input path and edge detect:
  - s = pwm_in after SYNC_STAGES flops; s_d = s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - All timing refers to s, so fixed input-to-measurement latency is SYNC_STAGES+1 cycles.
- States:
  - IDLE: waiting to arm. rise -> HIGH, cnt <= 1, no strobe. The first rise after reset or timeout only arms.
  - HIGH: cnt increments by 1 per cycle. fall -> LOW, hi_len <= cnt.
  - LOW: cnt increments by 1 per cycle. rise -> HIGH, and in the same cycle:
    - meas_period <= cnt, meas_high <= hi_len, cnt <= 1.
    - meas_valid = 1 in the following cycle only.
- Counting convention:
  - cnt = cycles elapsed since the last rise, counting the rise cycle as cycle 1.
  - Example: s high 3 cycles, then low 5 cycles -> meas_high = 3, meas_period = 8.
- Timeout:
  - In HIGH or LOW, if cnt reaches all-ones with no edge -> IDLE.
  - stuck_high <= s and stuck_low <= ~s.
  - cnt holds; meas_period and meas_high keep their last values; no meas_valid.
- Stuck clear: both stuck flags clear on the next rise or fall. A rise also arms (IDLE -> HIGH).
- Simultaneous events:
  - rise and fall cannot coincide (single signal).
  - Timeout and edge in the same cycle: the edge wins, no timeout.
- Outputs meas_period, meas_high, stuck_high, stuck_low are registered. meas_valid is registered and never high for two consecutive cycles.
- Minimum measurable period is 2 cycles of s. Glitches shorter than one clk are not filtered; no debounce in this block.

Decomposition:
- Shared package pwm_pkg:
  - state enum {IDLE, HIGH, LOW}.
  - default CNT_WIDTH constant.
  - saturated-count constant (all-ones).
- One natural sub-module: pwm_edge_sync. Contains the SYNC_STAGES synchronizer plus the s_d register, and outputs s, rise and fall.
- The state machine and counters stay in pwm_capture.

Test Plan:
- Reset, then pwm_in toggling 3 high / 5 low for 4 periods -> first rise arms only; meas_valid pulses 3 times; each pulse shows meas_period=8, meas_high=3; pulses spaced 8 cycles apart.
- 4-bit PWM source at duty 5 (period 16) -> meas_period=16, meas_high=5 on every strobe after arming. Change duty to 0 -> stuck_low=1 exactly 2^CNT_WIDTH-1 cycles after the last rise (use CNT_WIDTH=6 to keep the run short).
- pwm_in held high after a rise, CNT_WIDTH=6 -> stuck_high=1, stuck_low=0, no meas_valid, previous meas values held. Then drive low for 2 cycles and high again -> flags clear on the fall; the next rise only arms.
- Minimum period (1 high, 1 low repeating) -> meas_period=2, meas_high=1 on every strobe; meas_valid never high two cycles in a row.
- syn_rst asserted in the middle of a high phase -> all outputs 0 the cycle after; no strobe for the interrupted period; the next full period is measured correctly after re-arming.
- Edge arriving exactly on the timeout cycle (cnt at all-ones minus 1 when the edge is detected) -> edge processed normally, no stuck flag.
